// File: rtl/cache_pkg.sv
// Shared cache-subsystem constants and the fill-responder FSM state type.
package cache_pkg;
  localparam int LINE_ADDR_W    = 26;
  localparam int LINE_BYTES     = 64;
  localparam int WORD_BYTES     = 4;
  localparam int BEATS_PER_LINE = 16;

  typedef enum logic [1:0] {IDLE, WAIT, BURST} fill_state_e;
endpackage

// File: rtl/line_fill_responder_if.sv
// Request/response channels between an L1 I-cache and the line-fill responder.
interface line_fill_responder_if #(
  parameter int ADDR_W = 26,
  parameter int BEATS  = 16
);
  localparam int BEAT_W = $clog2(BEATS);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ADDR_W-1:0] rsp_addr;
  logic [BEAT_W-1:0] rsp_beat;
  logic              rsp_last;
  logic [31:0]       rsp_data;

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_addr, rsp_beat, rsp_last, rsp_data
  );

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_addr, rsp_beat, rsp_last, rsp_data
  );
endinterface

// File: rtl/fill_req_fifo.sv
// Small circular request FIFO; full/empty derive from an occupancy counter.
module fill_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 26
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_din,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end
endmodule

// File: rtl/line_fill_responder.sv
// Line-fill responder: queues line requests, waits a fixed latency, then
// streams each line as BEATS registered 32-bit beats; keeps fill statistics.
module line_fill_responder
  import cache_pkg::*;
#(
  parameter int ADDR_W  = LINE_ADDR_W,
  parameter int BEATS   = BEATS_PER_LINE,
  parameter int LATENCY = 20,
  parameter int QDEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stat_clr,
  line_fill_responder_if.slave  bus,
  output logic                  busy,
  output logic [31:0]           requests,
  output logic [31:0]           fills
);
  localparam int              BEAT_W    = $clog2(BEATS);
  localparam int              CNT_W     = $clog2(QDEPTH) + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [7:0]      LAT_INIT  = (LATENCY == 0) ? 8'd0 : 8'(LATENCY - 1);

  fill_state_e       r_state, w_state_nxt;
  logic [7:0]        r_lat_cnt, w_lat_nxt;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [BEAT_W-1:0] r_beat;
  logic [BEAT_W-1:0] w_beat_nxt;
  logic              r_last;
  logic              w_push, w_pop, w_full, w_empty;
  logic              w_beat_adv, w_fill_done;
  logic [ADDR_W-1:0] w_head;
  logic [CNT_W-1:0]  w_count;

  fill_req_fifo #(.DEPTH(QDEPTH), .WIDTH(ADDR_W)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_din  (bus.req_addr),
    .o_dout (w_head),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_count(w_count)
  );

  // A pop never frees a slot for a push in the same cycle.
  assign bus.req_ready = !w_full;
  assign w_push        = bus.req_valid && !w_full;
  assign busy          = (w_count != '0) || (r_state != IDLE);

  assign bus.rsp_valid = (r_state == BURST);
  assign bus.rsp_addr  = r_cur_addr;
  assign bus.rsp_beat  = r_beat;
  assign bus.rsp_last  = r_last;
  assign bus.rsp_data  = 32'({r_cur_addr, r_beat, 2'b00});
  assign w_beat_nxt    = r_beat + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_lat_nxt   = r_lat_cnt;
    w_pop       = 1'b0;
    w_beat_adv  = 1'b0;
    w_fill_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (LATENCY == 0) begin
            w_state_nxt = BURST;
          end else begin
            w_state_nxt = WAIT;
            w_lat_nxt   = LAT_INIT;
          end
        end
      end
      WAIT: begin
        if (r_lat_cnt == 8'd0) w_state_nxt = BURST;
        else                   w_lat_nxt   = r_lat_cnt - 8'd1;
      end
      BURST: begin
        if (bus.rsp_ready) begin
          w_beat_adv = 1'b1;
          if (r_beat == LAST_BEAT) begin
            w_fill_done = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_lat_cnt  <= '0;
      r_cur_addr <= '0;
      r_beat     <= '0;
      r_last     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_lat_cnt <= w_lat_nxt;
      if (w_pop) r_cur_addr <= w_head;
      // Beat index wraps to 0 after the final beat, ready for the next burst.
      if (w_beat_adv) begin
        r_beat <= w_beat_nxt;
        r_last <= (w_beat_nxt == LAST_BEAT);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      requests <= '0;
      fills    <= '0;
    end else if (stat_clr) begin
      requests <= '0;
      fills    <= '0;
    end else begin
      if (w_push)      requests <= requests + 32'd1;
      if (w_fill_done) fills    <= fills + 32'd1;
    end
  end
endmodule
